status_led_scheduler: RTL and testbench
=======================================

Name: status_led_scheduler

Overview:
- Shares the single board status LED among four status requesters: 0 heartbeat, 1 S/PDIF lock, 2 activity, 3 error.
- Each requester owns a fixed 16-step blink pattern.
- Arbitrates by fixed priority (3 highest), plays the granted pattern one step per tick, and re-arbitrates only at pattern boundaries. The exception is requester 3, which preempts immediately.
- Sits between the status sources and the LED pad; replaces free-running per-source pulse generators.

Parameters:
- CLOCK_HZ, 16000000, input clock frequency.
- STEP_HZ, 16, pattern step rate. DIV = CLOCK_HZ/STEP_HZ clock cycles per step; DIV >= 1 is required.
- PAT0, 16'h000F, heartbeat pattern, bit 0 played first.
- PAT1, 16'h00FF, lock pattern.
- PAT2, 16'h5555, activity pattern.
- PAT3, 16'h3333, error pattern.

Ports:
- clock_i  input  1  global clock
- reset_i  input  1  asynchronous, active-high reset
- req_i  input  4  level requests, bit n = requester n
- led_o  output  1  registered LED drive, 1 = on
- grant_o  output  2  index of the requester being played; valid while busy_o = 1
- busy_o  output  1  a pattern is playing
- frame_o  output  1  one-cycle pulse on the final cycle of a completed pattern

Behaviour:
- Reset (async assert, sync release): state IDLE; led_o=0, grant_o=0, busy_o=0, frame_o=0; prescaler=0; step=0.
- Reset mid-pattern aborts the pattern immediately; led_o goes to 0 asynchronously.
- Prescaler counts 0..DIV-1 while in PLAY. A tick occurs in the cycle where prescaler = DIV-1; prescaler then wraps to 0.
- Step counter is 4 bits, 0..15, and advances on each tick.
- States:
  - IDLE: led_o=0, busy_o=0. When req_i != 0 at a clock edge, on that edge:
    - grant = highest set bit;
    - step=0, prescaler=0;
    - led_o = PAT[grant][0], busy_o=1, state PLAY.
    - Latency from req sampled to LED valid: 1 cycle.
  - PLAY: led_o = PAT[grant][step], registered. Each step lasts exactly DIV cycles.
  - PLAY, tick at step 15 (pattern end):
    - frame_o=1 for that cycle.
    - On the same edge, if req_i != 0: re-grant the highest set bit, step=0, led_o = PAT[new][0]. Back-to-back patterns have no gap cycle.
    - Otherwise go to IDLE: led_o=0, busy_o=0.
- Deasserting a request mid-pattern does not abort; the pattern completes.
- Preemption: in PLAY with grant != 3, req_i[3] = 1 at an edge switches on that edge to grant=3, step=0, prescaler=0, led_o = PAT3[0]. frame_o stays 0 for the aborted pattern.
- Simultaneous preemption and pattern end: treat as a normal pattern end. frame_o=1, and grant=3 through priority.
- grant_o holds its last value while in IDLE. Observers qualify it with busy_o.
- DIV=1: a step advances every cycle. A pattern is then exactly 16 cycles, and frame_o fires in its 16th cycle.
- Prescaler width = max(1, clog2(DIV)). Compare against DIV-1 at full width; no truncation is allowed.

Decomposition:
- Shared package status_led_pkg holds:
  - requester index constants: REQ_HEARTBEAT=0, REQ_LOCK=1, REQ_ACTIVITY=2, REQ_ERROR=3;
  - NUM_REQ=4, STEPS=16;
  - the state enumeration IDLE/PLAY.
- One sub-module, led_step_timer:
  - parameter DIV; inputs clock_i, reset_i, clear_i, enable_i; output tick_o;
  - clear_i has priority over enable_i.
- The top level holds arbitration, the step counter and the pattern mux.

Test Plan (CLOCK_HZ=64, STEP_HZ=16 → DIV=4):
1. Reset idle: reset_i high for 3 cycles with req_i=4'b1111 → led_o=0, busy_o=0, frame_o=0 throughout; first edge after release → grant_o=3, busy_o=1.
2. Single heartbeat: req_i=4'b0001 held for 1 cycle then dropped → led_o=1 for 16 cycles, then 0 for 48 cycles; frame_o pulses once at cycle 64 after grant; then IDLE, busy_o=0.
3. Priority at boundary: start req_i=4'b0001, assert bit 1 at cycle 10 → heartbeat completes (frame_o at cycle 64); next edge grant_o=1, led_o=1 for 32 cycles, no idle gap.
4. Error preemption: PAT1 playing at step 5, assert req_i[3] → next edge grant_o=3, led_o follows 0011 per 4-cycle step (8 cycles on, 8 off, repeated); no frame_o for the aborted pattern.
5. Simultaneous end and preempt: assert req_i[3] exactly in the step-15 tick cycle of PAT0 → frame_o=1 that cycle; next edge grant_o=3, step 0.
6. Async reset mid-pattern: assert reset_i between clock edges during PAT2 with led_o=1 → led_o=0 immediately; after release with req_i=0, state stays IDLE.

Source files
------------

// File: rtl/status_led_pkg.sv
// Shared definitions for the status LED scheduler: requester indices,
// pattern geometry, the play-state enumeration and the priority encoder.
package status_led_pkg;

    localparam int NUM_REQ = 4;
    localparam int STEPS   = 16;

    localparam logic [1:0] REQ_HEARTBEAT = 2'd0;
    localparam logic [1:0] REQ_LOCK      = 2'd1;
    localparam logic [1:0] REQ_ACTIVITY  = 2'd2;
    localparam logic [1:0] REQ_ERROR     = 2'd3;

    localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Fixed priority: the error requester always wins.
    function automatic logic [1:0] highest_req(input logic [NUM_REQ-1:0] req);
        if (req[3])      return REQ_ERROR;
        else if (req[2]) return REQ_ACTIVITY;
        else if (req[1]) return REQ_LOCK;
        else             return REQ_HEARTBEAT;
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step prescaler: counts 0..DIV-1 while enabled and flags the last count
// of each step. clear_i forces the count back to zero and wins over enable_i.
module led_step_timer
    import status_led_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    // The tick is not masked by clear so the caller can tell a step end
    // from a restart in the same cycle.
    assign tick_o    = enable_i && w_at_last;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            if (w_at_last) r_cnt <= '0;
            else           r_cnt <= r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/status_led_scheduler.sv
// Shares one status LED among four requesters: fixed-priority arbitration at
// pattern boundaries, immediate preemption by the error requester.
module status_led_scheduler
    import status_led_pkg::*;
#(
    parameter int               CLOCK_HZ = 16000000,
    parameter int               STEP_HZ  = 16,
    parameter logic [STEPS-1:0] PAT0     = 16'h000F,
    parameter logic [STEPS-1:0] PAT1     = 16'h00FF,
    parameter logic [STEPS-1:0] PAT2     = 16'h5555,
    parameter logic [STEPS-1:0] PAT3     = 16'h3333
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic               led_o,
    output logic [1:0]         grant_o,
    output logic               busy_o,
    output logic               frame_o
);

    localparam int DIV = CLOCK_HZ / STEP_HZ;

    state_t     r_state;
    logic [3:0] r_step;
    logic [1:0] r_grant;
    logic       r_led;
    logic       r_busy;

    logic       w_tick;
    logic       w_pat_end;
    logic       w_preempt;
    logic       w_clear;
    logic       w_any_req;
    logic [1:0] w_winner;

    function automatic logic pat_bit(input logic [1:0] idx, input logic [3:0] stp);
        case (idx)
            REQ_HEARTBEAT: pat_bit = PAT0[stp];
            REQ_LOCK:      pat_bit = PAT1[stp];
            REQ_ACTIVITY:  pat_bit = PAT2[stp];
            default:       pat_bit = PAT3[stp];
        endcase
    endfunction

    assign w_any_req = |req_i;
    assign w_winner  = highest_req(req_i);
    assign w_pat_end = (r_state == PLAY) && w_tick && (r_step == LAST_STEP);
    // A pattern that ends on the same edge is not preempted; priority picks 3.
    assign w_preempt = (r_state == PLAY) && (r_grant != REQ_ERROR) &&
                       req_i[REQ_ERROR] && !w_pat_end;
    assign w_clear   = (r_state != PLAY) || w_preempt;

    led_step_timer #(
        .DIV(DIV)
    ) u_timer (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (w_clear),
        .enable_i(r_state == PLAY),
        .tick_o  (w_tick)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_grant <= REQ_HEARTBEAT;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= PLAY;
                        r_grant <= w_winner;
                        r_step  <= '0;
                        r_led   <= pat_bit(w_winner, 4'd0);
                        r_busy  <= 1'b1;
                    end
                end
                PLAY: begin
                    if (w_preempt) begin
                        r_grant <= REQ_ERROR;
                        r_step  <= '0;
                        r_led   <= PAT3[0];
                    end else if (w_pat_end) begin
                        r_step <= '0;
                        if (w_any_req) begin
                            r_grant <= w_winner;
                            r_led   <= pat_bit(w_winner, 4'd0);
                        end else begin
                            r_state <= IDLE;
                            r_led   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_tick) begin
                        r_step <= r_step + 4'd1;
                        r_led  <= pat_bit(r_grant, r_step + 4'd1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign led_o   = r_led;
    assign grant_o = r_grant;
    assign busy_o  = r_busy;
    assign frame_o = w_pat_end;

endmodule

// File: tb/tb_status_led_scheduler.sv
// Directed bench for status_led_scheduler with DIV=4 (64 Hz clock, 16 Hz steps).
module tb_status_led_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       led;
    logic [1:0] grant;
    logic       busy;
    logic       frame;

    int total = 0;
    int bad   = 0;

    status_led_scheduler #(
        .CLOCK_HZ(64),
        .STEP_HZ (16),
        .PAT0    (16'h000F),
        .PAT1    (16'h00FF),
        .PAT2    (16'h5555),
        .PAT3    (16'h3333)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .req_i  (req),
        .led_o  (led),
        .grant_o(grant),
        .busy_o (busy),
        .frame_o(frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Start a pattern: req is sampled on the next edge; returns in cycle 1.
    task automatic start_req(input logic [3:0] r);
        req = r;
        next_cycle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({led, busy, frame} !== 3'b000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got led/busy/frame=%b want 000", i, {led, busy, frame});
            end
        end
        rst = 1'b0;
        next_cycle();
        total++;
        if (grant !== 2'd3 || busy !== 1'b1 || led !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got grant=%0d busy=%b led=%b want 3 1 1", grant, busy, led);
        end
        do_reset();
    endtask

    task automatic test_heartbeat();
        start_req(4'b0001);
        req = 4'b0000;
        for (int c = 1; c <= 64; c++) begin
            total++;
            if (led !== (c <= 16) || frame !== (c == 64) || busy !== 1'b1 || grant !== 2'd0) begin
                bad++;
                $display("FAIL heartbeat c=%0d got led=%b frame=%b busy=%b grant=%0d want led=%b frame=%b busy=1 grant=0",
                         c, led, frame, busy, grant, (c <= 16), (c == 64));
            end
            next_cycle();
        end
        total++;
        if (busy !== 1'b0 || led !== 1'b0 || frame !== 1'b0 || grant !== 2'd0) begin
            bad++;
            $display("FAIL heartbeat_idle got busy=%b led=%b frame=%b grant=%0d want 0 0 0 0", busy, led, frame, grant);
        end
    endtask

    task automatic test_priority_boundary();
        start_req(4'b0001);
        for (int c = 1; c <= 64; c++) begin
            if (c == 10) req = 4'b0011;
            total++;
            if (led !== (c <= 16) || frame !== (c == 64) || grant !== 2'd0) begin
                bad++;
                $display("FAIL prio_first c=%0d got led=%b frame=%b grant=%0d want led=%b frame=%b grant=0",
                         c, led, frame, grant, (c <= 16), (c == 64));
            end
            next_cycle();
        end
        req = 4'b0000;
        for (int c = 1; c <= 64; c++) begin
            total++;
            if (led !== (c <= 32) || frame !== (c == 64) || grant !== 2'd1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL prio_second c=%0d got led=%b frame=%b grant=%0d busy=%b want led=%b frame=%b grant=1 busy=1",
                         c, led, frame, grant, busy, (c <= 32), (c == 64));
            end
            next_cycle();
        end
        total++;
        if (busy !== 1'b0 || grant !== 2'd1) begin
            bad++;
            $display("FAIL prio_idle got busy=%b grant=%0d want 0 1", busy, grant);
        end
    endtask

    task automatic test_error_preempt();
        start_req(4'b0010);
        req = 4'b0000;
        for (int c = 1; c <= 22; c++) begin
            if (c == 22) req = 4'b1000;
            total++;
            if (led !== 1'b1 || frame !== 1'b0 || grant !== 2'd1) begin
                bad++;
                $display("FAIL preempt_pre c=%0d got led=%b frame=%b grant=%0d want 1 0 1", c, led, frame, grant);
            end
            next_cycle();
        end
        req = 4'b0000;
        for (int c = 1; c <= 64; c++) begin
            total++;
            if (led !== ((((c - 1) / 4) % 4) < 2) || frame !== (c == 64) || grant !== 2'd3) begin
                bad++;
                $display("FAIL preempt_err c=%0d got led=%b frame=%b grant=%0d want led=%b frame=%b grant=3",
                         c, led, frame, grant, ((((c - 1) / 4) % 4) < 2), (c == 64));
            end
            next_cycle();
        end
        total++;
        if (busy !== 1'b0 || led !== 1'b0 || grant !== 2'd3) begin
            bad++;
            $display("FAIL preempt_idle got busy=%b led=%b grant=%0d want 0 0 3", busy, led, grant);
        end
    endtask

    task automatic test_end_and_preempt();
        start_req(4'b0001);
        req = 4'b0000;
        for (int c = 1; c < 64; c++) next_cycle();
        req = 4'b1000;
        total++;
        if (frame !== 1'b1 || grant !== 2'd0) begin
            bad++;
            $display("FAIL endpre_frame got frame=%b grant=%0d want 1 0", frame, grant);
        end
        next_cycle();
        req = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            total++;
            if (led !== (c <= 8) || grant !== 2'd3 || busy !== 1'b1 || frame !== 1'b0) begin
                bad++;
                $display("FAIL endpre_err c=%0d got led=%b grant=%0d busy=%b frame=%b want led=%b grant=3 busy=1 frame=0",
                         c, led, grant, busy, frame, (c <= 8));
            end
            next_cycle();
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        start_req(4'b0100);
        req = 4'b0000;
        next_cycle();
        total++;
        if (led !== 1'b1 || grant !== 2'd2) begin
            bad++;
            $display("FAIL areset_pre got led=%b grant=%0d want 1 2", led, grant);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (led !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL areset_now got led=%b busy=%b want 0 0", led, busy);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            total++;
            if (led !== 1'b0 || busy !== 1'b0 || frame !== 1'b0) begin
                bad++;
                $display("FAIL areset_idle c=%0d got led=%b busy=%b frame=%b want 000", c, led, busy, frame);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        test_reset();
        test_heartbeat();
        test_priority_boundary();
        test_error_preempt();
        test_end_and_preempt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
